// File: rtl/cpa_pkg.sv
// Shared state encoding and sizing helpers for the segmented carry-propagate adder.
package cpa_pkg;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } cpaState_t;

   function automatic int calcNseg(input int dataW, input int segW);
      return dataW / segW;
   endfunction

   // A single-segment build still needs a 1-bit counter to keep the port widths legal.
   function automatic int calcCntW(input int nseg);
      return (nseg > 1) ? $clog2(nseg) : 1;
   endfunction

endpackage

// File: rtl/cpa_cla16.sv
// 16-bit two-level carry-lookahead adder: four leaf lookahead cells under one root cell.
module cpa_cla16 (
   input  logic [15:0] i_a,
   input  logic [15:0] i_b,
   input  logic        i_cin,
   output logic [15:0] o_sum,
   output logic        o_p,
   output logic        o_g,
   output logic        o_cout
);

   logic [15:0] w_p;
   logic [15:0] w_g;
   logic [15:0] w_c;
   logic [3:0]  w_leafP;
   logic [3:0]  w_leafG;
   logic [3:0]  w_rootC;

   assign w_p = i_a ^ i_b;
   assign w_g = i_a & i_b;

   // The root resolves the carry into each nibble; each leaf then resolves its own bits.
   for (genvar i = 0; i < 4; i++) begin : g_leaf
      lookahead_generator_x4 u_leaf (
         .i_p   (w_p[4*i +: 4]),
         .i_g   (w_g[4*i +: 4]),
         .i_cin (w_rootC[i]),
         .o_c   (w_c[4*i +: 4]),
         .o_pg  (w_leafP[i]),
         .o_gg  (w_leafG[i])
      );
   end

   lookahead_generator_x4 u_root (
      .i_p   (w_leafP),
      .i_g   (w_leafG),
      .i_cin (i_cin),
      .o_c   (w_rootC),
      .o_pg  (o_p),
      .o_gg  (o_g)
   );

   assign o_sum  = w_p ^ w_c;
   assign o_cout = o_g | (o_p & i_cin);

endmodule

// File: rtl/lookahead_generator_x4.sv
// Four-bit carry-lookahead cell: per-position carries plus group propagate/generate.
module lookahead_generator_x4 (
   input  logic [3:0] i_p,
   input  logic [3:0] i_g,
   input  logic       i_cin,
   output logic [3:0] o_c,
   output logic       o_pg,
   output logic       o_gg
);

   // o_c[n] is the carry into position n, so o_c[0] is simply the incoming carry.
   assign o_c[0] = i_cin;
   assign o_c[1] = i_g[0] | (i_p[0] & i_cin);
   assign o_c[2] = i_g[1] | (i_p[1] & i_g[0]) | (i_p[1] & i_p[0] & i_cin);
   assign o_c[3] = i_g[2] | (i_p[2] & i_g[1]) | (i_p[2] & i_p[1] & i_g[0])
                 | (&i_p[2:0] & i_cin);

   assign o_pg = &i_p;
   assign o_gg = i_g[3] | (i_p[3] & i_g[2]) | (i_p[3] & i_p[2] & i_g[1])
               | (&i_p[3:1] & i_g[0]);

endmodule

// File: rtl/cpa_segmented_adder.sv
// Multi-cycle wide adder, SEG_W bits per cycle with a registered inter-segment carry.
// Optional subtract mode (in_sub port) is enabled by defining CPA_SUB_EN.
module cpa_segmented_adder
   import cpa_pkg::*;
#(
   parameter int DATA_W = 256,
   parameter int SEG_W  = 64
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_a,
   input  logic [DATA_W-1:0] in_b,
   input  logic              in_cin,
`ifdef CPA_SUB_EN
   input  logic              in_sub,
`endif
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_sum,
   output logic              out_cout
);

   localparam int NSEG  = calcNseg(DATA_W, SEG_W);
   localparam int CNT_W = calcCntW(NSEG);
   localparam int NGRP  = SEG_W / 16;

   cpaState_t          r_state;
   logic [CNT_W-1:0]   r_cnt;
   logic               r_carry;
   logic [DATA_W-1:0]  r_opA;
   logic [DATA_W-1:0]  r_opB;
   logic [DATA_W-1:0]  r_sum;

   logic [SEG_W-1:0]        w_segSum;
   logic [NGRP:0]           w_grpCarry;
   logic [NGRP-1:0]         w_grpP;
   logic [NGRP-1:0]         w_grpG;
   logic [DATA_W+SEG_W-1:0] w_sumShift;
   logic [DATA_W-1:0]       w_bCapture;
   logic                    w_carryCapture;

   assign w_grpCarry[0] = r_carry;

   // Groups ripple their carries combinationally inside one segment.
   for (genvar k = 0; k < NGRP; k++) begin : g_grp
      cpa_cla16 u_cla (
         .i_a    (r_opA[16*k +: 16]),
         .i_b    (r_opB[16*k +: 16]),
         .i_cin  (w_grpCarry[k]),
         .o_sum  (w_segSum[16*k +: 16]),
         .o_p    (w_grpP[k]),
         .o_g    (w_grpG[k]),
         .o_cout (w_grpCarry[k+1])
      );
   end

   // New segment enters at the top so after NSEG steps segment 0 lands at the bottom.
   assign w_sumShift = {w_segSum, r_sum};

`ifdef CPA_SUB_EN
   assign w_bCapture     = in_sub ? ~in_b : in_b;
   assign w_carryCapture = in_sub ? 1'b1 : in_cin;
`else
   assign w_bCapture     = in_b;
   assign w_carryCapture = in_cin;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_carry <= 1'b0;
         r_opA   <= '0;
         r_opB   <= '0;
         r_sum   <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (in_valid) begin
                  r_opA   <= in_a;
                  r_opB   <= w_bCapture;
                  r_carry <= w_carryCapture;
                  r_cnt   <= '0;
                  r_state <= RUN;
               end
            end
            RUN: begin
               r_sum   <= w_sumShift[DATA_W+SEG_W-1:SEG_W];
               r_opA   <= r_opA >> SEG_W;
               r_opB   <= r_opB >> SEG_W;
               r_carry <= w_grpCarry[NGRP];
               r_cnt   <= r_cnt + CNT_W'(1);
               if (r_cnt == CNT_W'(NSEG - 1)) begin
                  r_state <= DONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  r_state <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign in_ready  = (r_state == IDLE) && !rst;
   assign out_valid = (r_state == DONE);
   assign out_sum   = r_sum;
   assign out_cout  = r_carry;

endmodule

// File: tb/tb_cpa_segmented_adder.sv
// Directed-vector bench for cpa_segmented_adder at DATA_W=256, SEG_W=64 (four segments).
module tb_cpa_segmented_adder;

   localparam int DATA_W = 256;
   localparam int SEG_W  = 64;
   localparam int NSEG   = 4;

   logic              clk = 1'b0;
   logic              rst;
   logic              inValid;
   logic              inReady;
   logic [DATA_W-1:0] inA;
   logic [DATA_W-1:0] inB;
   logic              inCin;
   logic              inSub;
   logic              outValid;
   logic              outReady;
   logic [DATA_W-1:0] outSum;
   logic              outCout;

   int errors = 0;
   int checks = 0;
   int latency;
   logic sawValid;
   logic [DATA_W-1:0] allOnes;

   always #5 clk = ~clk;

   cpa_segmented_adder #(
      .DATA_W (DATA_W),
      .SEG_W  (SEG_W)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (inValid),
      .in_ready  (inReady),
      .in_a      (inA),
      .in_b      (inB),
      .in_cin    (inCin),
`ifdef CPA_SUB_EN
      .in_sub    (inSub),
`endif
      .out_valid (outValid),
      .out_ready (outReady),
      .out_sum   (outSum),
      .out_cout  (outCout)
   );

   task automatic checkOutput(input string tag, input logic [DATA_W:0] actual,
                              input logic [DATA_W:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
      end
   endtask

   // Waits for in_ready, presents one operation, and counts edges until out_valid.
   task automatic applyStimulus(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                                input logic cin, input logic sub, output int lat);
      int budget = 0;
      while (!inReady && budget < 50) begin
         @(posedge clk); #1;
         budget++;
      end
      checkOutput("inReadyBeforeIssue", inReady, 1);
      inA = a;
      inB = b;
      inCin = cin;
      inSub = sub;
      inValid = 1'b1;
      @(posedge clk); #1;
      inValid = 1'b0;
      lat = 0;
      while (!outValid && lat < 50) begin
         @(posedge clk); #1;
         lat++;
      end
   endtask

   initial begin
      allOnes  = '1;
      rst      = 1'b1;
      inValid  = 1'b0;
      inA      = '0;
      inB      = '0;
      inCin    = 1'b0;
      inSub    = 1'b0;
      outReady = 1'b1;

      repeat (3) @(posedge clk);
      #1;
      checkOutput("inReadyDuringReset", inReady, 0);
      checkOutput("outValidReset", outValid, 0);
      checkOutput("outSumReset", outSum, 0);
      checkOutput("outCoutReset", outCout, 0);
      rst = 1'b0;
      #1;
      checkOutput("inReadyAfterReset", inReady, 1);

      // 1 + 2: latency, result and return to IDLE.
      applyStimulus(256'd1, 256'd2, 1'b0, 1'b0, latency);
      checkOutput("latency1p2", latency, NSEG);
      checkOutput("sum1p2", outSum, 3);
      checkOutput("cout1p2", outCout, 0);
      @(posedge clk); #1;
      checkOutput("outValidDrop", outValid, 0);
      checkOutput("inReadyReturn", inReady, 1);

      // Carry ripples through every segment.
      applyStimulus(allOnes, 256'd0, 1'b1, 1'b0, latency);
      checkOutput("latencyRipple", latency, NSEG);
      checkOutput("sumRipple", outSum, 0);
      checkOutput("coutRipple", outCout, 1);
      @(posedge clk); #1;

      // Segment 0 -> 1 boundary.
      applyStimulus({192'd0, 64'hFFFF_FFFF_FFFF_FFFF}, 256'd1, 1'b0, 1'b0, latency);
      checkOutput("sumSeg01", outSum, {191'd0, 1'b1, 64'd0});
      checkOutput("coutSeg01", outCout, 0);
      @(posedge clk); #1;

      // (2^192-1) + (2^192-1) = 2^193-2, crossing into the top segment.
      applyStimulus({64'd0, {192{1'b1}}}, {64'd0, {192{1'b1}}}, 1'b0, 1'b0, latency);
      checkOutput("sumSeg23", outSum, {63'd0, 1'b1, {191{1'b1}}, 1'b0});
      checkOutput("coutSeg23", outCout, 0);
      @(posedge clk); #1;

      // 2^255 + 2^255 wraps to zero with the carry reported on out_cout.
      applyStimulus({1'b1, 255'd0}, {1'b1, 255'd0}, 1'b0, 1'b0, latency);
      checkOutput("sumWrap", outSum, 0);
      checkOutput("coutWrap", outCout, 1);
      @(posedge clk); #1;

      // Back-pressure: result must hold while in_valid pulses are ignored.
      outReady = 1'b0;
      applyStimulus(256'd100, 256'd23, 1'b1, 1'b0, latency);
      for (int i = 0; i < 10; i++) begin
         inA = 256'(i + 1000);
         inB = 256'(i * 7);
         inValid = (i % 2 == 0);
         @(posedge clk); #1;
         checkOutput("holdValid", outValid, 1);
         checkOutput("holdSum", outSum, 124);
      end
      inValid = 1'b0;
      outReady = 1'b1;
      @(posedge clk); #1;
      checkOutput("holdRelease", outValid, 0);
      checkOutput("holdInReady", inReady, 1);
      checkOutput("holdSumKept", outSum, 124);

      // Reset during the second RUN cycle abandons the operation.
      inA = 256'd9;
      inB = 256'd9;
      inCin = 1'b0;
      inValid = 1'b1;
      @(posedge clk); #1;
      inValid = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      checkOutput("inReadyMidReset", inReady, 0);
      @(posedge clk); #1;
      checkOutput("outValidMidReset", outValid, 0);
      checkOutput("inReadyHeldReset", inReady, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      sawValid = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1;
         if (outValid) sawValid = 1'b1;
      end
      checkOutput("noValidAfterAbort", sawValid, 0);
      checkOutput("idleAfterAbort", inReady, 1);
      applyStimulus(256'd5, 256'd7, 1'b0, 1'b0, latency);
      checkOutput("sum5p7", outSum, 12);
      checkOutput("cout5p7", outCout, 0);
      @(posedge clk); #1;

`ifdef CPA_SUB_EN
      applyStimulus(256'd5, 256'd7, 1'b1, 1'b1, latency);
      checkOutput("sub5m7", outSum, {1'b0, allOnes - 256'd1});
      checkOutput("borrow5m7", outCout, 0);
      @(posedge clk); #1;
      applyStimulus(256'd7, 256'd5, 1'b0, 1'b1, latency);
      checkOutput("sub7m5", outSum, 2);
      checkOutput("borrow7m5", outCout, 1);
      @(posedge clk); #1;
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
